// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the RAM arbiter and its round-robin core.
package ram_arbiter_pkg;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned GNT_ID_W = 3;
  localparam int unsigned CNT_W    = 16;

  typedef logic [GNT_ID_W-1:0] gnt_id_t;

  // Read-return tracking stage: read flag plus the id of the requester it belongs to.
  typedef struct packed {
    logic    rd;
    gnt_id_t id;
  } rd_stage_t;

endpackage

// File: rtl/ram_arbiter_rr.sv
// rr_arbiter: round-robin arbiter, one-hot grant computed combinationally from the
// request vector and the last-grant pointer.
module rr_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant_c,
  output gnt_id_t            gnt_id_c,
  output logic               gnt_any_c
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SH_W  = IDX_W + 1;

  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] req_m;
  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_gnt;
  logic [SH_W-1:0]    sh;

  // Nothing is granted while reset is held.
  assign req_m     = rst ? '0 : req;
  assign gnt_any_c = |req_m;

  // Rotate so bit 0 is the requester right after the last grantee, take the
  // lowest set bit, then rotate the winner back into requester order.
  assign sh      = {1'b0, ptr_q} + SH_W'(1);
  assign rot_req = NUM_REQ'({req_m, req_m} >> sh);
  assign rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
  assign grant_c = NUM_REQ'(({rot_gnt, rot_gnt} << sh) >> NUM_REQ);

  // One-hot to binary grant id.
  for (genvar b = 0; b < GNT_ID_W; b++) begin : g_enc
    logic [NUM_REQ-1:0] sel;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sel
      localparam bit HAS_BIT = ((i >> b) & 1) != 0;
      assign sel[i] = grant_c[i] & HAS_BIT;
    end
    assign gnt_id_c[b] = |sel;
  end

  // Last-grant pointer; reset value makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (gnt_any_c) begin
      ptr_q <= IDX_W'(gnt_id_c);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port among NUM_REQ requesters with round-robin
// arbitration and routes read data back as a one-hot response strobe.
// Optional feature macro RAM_ARBITER_STATS_EN adds per-requester saturating
// grant counters on output grant_cnt.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RDELAY     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_data,
  input  logic                          ram_valid
`ifdef RAM_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]      grant_cnt
`endif
);

  logic [NUM_REQ-1:0] grant_c;
  gnt_id_t            gnt_id_c;
  logic               gnt_any_c;
  logic               rsp_hit_c;
  gnt_id_t            rsp_id_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .grant_c   (grant_c),
    .gnt_id_c  (gnt_id_c),
    .gnt_any_c (gnt_any_c)
  );

  assign req_ready = grant_c;
  assign ram_en    = gnt_any_c;
  assign ram_we    = |(grant_c & req_we);

  // Grant-selected address, AND-OR muxed bit by bit.
  for (genvar a = 0; a < ADDR_WIDTH; a++) begin : g_addr
    logic [NUM_REQ-1:0] col;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign col[i] = grant_c[i] & req_addr[i*ADDR_WIDTH + a];
    end
    assign ram_addr[a] = |col;
  end

  // Grant-selected write data, AND-OR muxed bit by bit.
  for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_wdata
    logic [NUM_REQ-1:0] col;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign col[i] = grant_c[i] & req_wdata[i*DATA_WIDTH + d];
    end
    assign ram_wdata[d] = |col;
  end

  if (RDELAY == 1) begin : g_rd_reg
    rd_stage_t rd_q;

    // Track this cycle's read grant so the RAM return one cycle later can be routed.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q.rd <= gnt_any_c & ~ram_we;
        rd_q.id <= gnt_id_c;
      end
    end

    assign rsp_hit_c = rd_q.rd & ram_valid & ~rst;
    assign rsp_id_c  = rd_q.id;
  end else begin : g_rd_comb
    assign rsp_hit_c = gnt_any_c & ~ram_we & ram_valid;
    assign rsp_id_c  = gnt_id_c;
  end

  // Steer the response strobe to the requester that issued the read.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = rsp_hit_c & (rsp_id_c == GNT_ID_W'(i));
  end

  assign rsp_data = rsp_hit_c ? ram_data : '0;

`ifdef RAM_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Count grants to requester i, holding at all-ones.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (grant_c[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a 4-requester RDELAY=1 instance and a 2-requester
// RDELAY=0 instance, each with a behavioural RAM attached.
module tb_ram_arbiter;

  localparam int NA = 4;
  localparam int NB = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NUM_REQ=4, RDELAY=1
  logic [NA-1:0]    a_valid, a_we, a_ready, a_rsp_valid;
  logic [NA*AW-1:0] a_addr;
  logic [NA*DW-1:0] a_wdata;
  logic [DW-1:0]    a_rsp_data, a_ram_wdata, a_ram_data;
  logic [AW-1:0]    a_ram_addr;
  logic             a_ram_en, a_ram_we, a_ram_valid;

  // Instance B: NUM_REQ=2, RDELAY=0
  logic [NB-1:0]    b_valid, b_we, b_ready, b_rsp_valid;
  logic [NB*AW-1:0] b_addr;
  logic [NB*DW-1:0] b_wdata;
  logic [DW-1:0]    b_rsp_data, b_ram_wdata, b_ram_data;
  logic [AW-1:0]    b_ram_addr;
  logic             b_ram_en, b_ram_we, b_ram_valid;

`ifdef RAM_ARBITER_STATS_EN
  logic [NA*16-1:0] a_cnt;
  logic [NB*16-1:0] b_cnt;
`endif

  ram_arbiter #(.NUM_REQ(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDELAY(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_data(a_ram_data), .ram_valid(a_ram_valid)
`ifdef RAM_ARBITER_STATS_EN
    , .grant_cnt(a_cnt)
`endif
  );

  ram_arbiter #(.NUM_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDELAY(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_data(b_ram_data), .ram_valid(b_ram_valid)
`ifdef RAM_ARBITER_STATS_EN
    , .grant_cnt(b_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int addr);
    return 32'hC0DE0000 | 32'(addr);
  endfunction

  // Behavioural RAMs: A has one cycle of read latency, B reads combinationally.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = init_val(i);
      mem_b[i] = init_val(i);
    end
  end

  always @(posedge clk) begin
    if (a_ram_en && a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
    a_ram_valid <= a_ram_en && !a_ram_we;
    a_ram_data  <= mem_a[a_ram_addr];
  end

  always @(posedge clk) begin
    if (b_ram_en && b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
  end

  assign b_ram_data  = mem_b[b_ram_addr];
  assign b_ram_valid = b_ram_en && !b_ram_we;

  task automatic set_a(input int i, input logic v, input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d);
    a_valid[i]           = v;
    a_we[i]              = we;
    a_addr[i*AW +: AW]   = ad;
    a_wdata[i*DW +: DW]  = d;
  endtask

  task automatic set_b(input int i, input logic v, input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d);
    b_valid[i]           = v;
    b_we[i]              = we;
    b_addr[i*AW +: AW]   = ad;
    b_wdata[i*DW +: DW]  = d;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    a_valid = '0;
    b_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    a_valid = '1; a_we = '0;
    b_valid = '1; b_we = '0;
    #1;
    checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL rst_a_ready: got %b exp 0000", a_ready); end
    checks++; if (a_ram_en !== 1'b0) begin errors++; $display("FAIL rst_a_ram_en: got %b exp 0", a_ram_en); end
    checks++; if (a_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_a_rsp_valid: got %b exp 0000", a_rsp_valid); end
    checks++; if (a_rsp_data !== 32'h0) begin errors++; $display("FAIL rst_a_rsp_data: got %h exp 0", a_rsp_data); end
    checks++; if (b_ready !== 2'b00) begin errors++; $display("FAIL rst_b_ready: got %b exp 00", b_ready); end
    checks++; if (b_ram_en !== 1'b0) begin errors++; $display("FAIL rst_b_ram_en: got %b exp 0", b_ram_en); end
    checks++; if (b_rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_b_rsp_valid: got %b exp 00", b_rsp_valid); end
    checks++; if (b_rsp_data !== 32'h0) begin errors++; $display("FAIL rst_b_rsp_data: got %h exp 0", b_rsp_data); end
    @(negedge clk);
    rst = 1'b0;
    a_valid = '0;
    b_valid = '0;
  endtask

  task automatic test_write_read;
    do_reset;
    @(negedge clk);
    set_a(0, 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5);
    #1;
    checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL wr_grant: got %b exp 0001", a_ready); end
    checks++; if ({a_ram_en, a_ram_we} !== 2'b11) begin errors++; $display("FAIL wr_en_we: got %b exp 11", {a_ram_en, a_ram_we}); end
    checks++; if (a_ram_addr !== 8'h10) begin errors++; $display("FAIL wr_addr: got %h exp 10", a_ram_addr); end
    checks++; if (a_ram_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_wdata: got %h exp a5a5a5a5", a_ram_wdata); end
    @(negedge clk);
    set_a(0, 1'b1, 1'b0, 8'h10, 32'h0);
    #1;
    checks++; if ({a_ready, a_ram_we} !== 5'b0001_0) begin errors++; $display("FAIL rd_grant: got %b exp 00010", {a_ready, a_ram_we}); end
    checks++; if (a_rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_no_rsp: got %b exp 0000", a_rsp_valid); end
    @(negedge clk);
    a_valid = '0;
    #1;
    checks++; if (a_rsp_valid !== 4'b0001) begin errors++; $display("FAIL rd_rsp_valid: got %b exp 0001", a_rsp_valid); end
    checks++; if (a_rsp_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL rd_rsp_data: got %h exp a5a5a5a5", a_rsp_data); end
    @(negedge clk);
    #1;
    checks++; if (a_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rd_rsp_once: got %b exp 0000", a_rsp_valid); end
  endtask

  // Two (or more) held reads: expected grant sequence given as ids g0/g1 alternating.
  task automatic run_pair(input string nm, input int g0, input int g1);
    logic [NA-1:0] exp_r;
    logic [NA-1:0] exp_v;
    logic [DW-1:0] exp_d;
    int            prev;
    do_reset;
    @(negedge clk);
    a_valid = '0;
    set_a(g0, 1'b1, 1'b0, AW'(8'h20 + g0), 32'h0);
    set_a(g1, 1'b1, 1'b0, AW'(8'h20 + g1), 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) a_valid = '0;
      #1;
      exp_r = (c == 4) ? '0 : (NA'(1) << ((c % 2 == 0) ? g0 : g1));
      checks++;
      if (a_ready !== exp_r) begin errors++; $display("FAIL %s_grant%0d: got %b exp %b", nm, c, a_ready, exp_r); end
      prev  = (c % 2 == 1) ? g0 : g1;
      exp_v = (c == 0) ? '0 : (NA'(1) << prev);
      exp_d = init_val(32 + prev);
      checks++;
      if (a_rsp_valid !== exp_v) begin errors++; $display("FAIL %s_rsp%0d: got %b exp %b", nm, c, a_rsp_valid, exp_v); end
      if (c > 0) begin
        checks++;
        if (a_rsp_data !== exp_d) begin errors++; $display("FAIL %s_data%0d: got %h exp %h", nm, c, a_rsp_data, exp_d); end
      end
    end
  endtask

  task automatic test_round_robin;
    run_pair("rr01", 0, 1);
  endtask

  task automatic test_alternate;
    run_pair("alt13", 1, 3);
  endtask

  task automatic test_reset_mid;
    do_reset;
    @(negedge clk);
    a_valid = '0;
    set_a(0, 1'b1, 1'b0, 8'h40, 32'h0);
    #1;
    checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b exp 0001", a_ready); end
    @(negedge clk);
    rst = 1'b1;
    a_valid = '0;
    #1;
    checks++; if (a_rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_in_rst: got %b exp 0000", a_rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    set_a(0, 1'b1, 1'b0, 8'h40, 32'h0);
    set_a(1, 1'b1, 1'b0, 8'h41, 32'h0);
    #1;
    checks++; if (a_rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_after_rst: got %b exp 0000", a_rsp_valid); end
    checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b exp 0001", a_ready); end
    @(negedge clk);
    a_valid = '0;
    #1;
    checks++; if (a_rsp_valid !== 4'b0001) begin errors++; $display("FAIL mid_post_rsp: got %b exp 0001", a_rsp_valid); end
    checks++; if (a_rsp_data !== init_val(8'h40)) begin errors++; $display("FAIL mid_post_data: got %h exp %h", a_rsp_data, init_val(8'h40)); end
  endtask

  task automatic test_rdelay0;
    do_reset;
    @(negedge clk);
    b_valid = '0;
    set_b(0, 1'b1, 1'b1, 8'h02, 32'h1234);
    #1;
    checks++; if (b_ready !== 2'b01) begin errors++; $display("FAIL r0_wr_grant: got %b exp 01", b_ready); end
    checks++; if (b_rsp_valid !== 2'b00) begin errors++; $display("FAIL r0_wr_no_rsp: got %b exp 00", b_rsp_valid); end
    @(negedge clk);
    set_b(0, 1'b1, 1'b0, 8'h02, 32'h0);
    #1;
    checks++; if (b_ready !== 2'b01) begin errors++; $display("FAIL r0_rd_grant: got %b exp 01", b_ready); end
    checks++; if (b_rsp_valid !== 2'b01) begin errors++; $display("FAIL r0_rd_rsp: got %b exp 01", b_rsp_valid); end
    checks++; if (b_rsp_data !== 32'h1234) begin errors++; $display("FAIL r0_rd_data: got %h exp 1234", b_rsp_data); end
    @(negedge clk);
    set_b(0, 1'b1, 1'b0, 8'h05, 32'h0);
    set_b(1, 1'b1, 1'b0, 8'h06, 32'h0);
    #1;
    checks++; if ({b_ready, b_rsp_valid} !== 4'b10_10) begin errors++; $display("FAIL r0_pair1: got %b exp 1010", {b_ready, b_rsp_valid}); end
    checks++; if (b_rsp_data !== init_val(6)) begin errors++; $display("FAIL r0_pair1_data: got %h exp %h", b_rsp_data, init_val(6)); end
    @(negedge clk);
    #1;
    checks++; if ({b_ready, b_rsp_valid} !== 4'b01_01) begin errors++; $display("FAIL r0_pair2: got %b exp 0101", {b_ready, b_rsp_valid}); end
    checks++; if (b_rsp_data !== init_val(5)) begin errors++; $display("FAIL r0_pair2_data: got %h exp %h", b_rsp_data, init_val(5)); end
    @(negedge clk);
    b_valid = '0;
    #1;
    checks++; if ({b_ready, b_rsp_valid, b_ram_en} !== 5'b0) begin errors++; $display("FAIL r0_idle: got %b exp 00000", {b_ready, b_rsp_valid, b_ram_en}); end
  endtask

  // Random traffic on instance A against a transaction-level model.
  task automatic test_random;
    bit            pv  [NA];
    bit            pwe [NA];
    logic [AW-1:0] pad [NA];
    logic [DW-1:0] pwd [NA];
    logic [DW-1:0] mdl [256];
    int            mptr;
    int            g;
    int            j;
    logic [NA-1:0] exp_ready;
    logic [NA-1:0] exp_rsp;
    logic [NA-1:0] nxt_rsp;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] nxt_data;
    for (int i = 0; i < 256; i++) mdl[i] = init_val(i);
    for (int i = 0; i < NA; i++) pv[i] = 1'b0;
    do_reset;
    mptr     = NA - 1;
    exp_rsp  = '0;
    exp_data = '0;
    repeat (600) begin
      @(negedge clk);
      for (int i = 0; i < NA; i++) begin
        if (!pv[i] && ($urandom_range(0, 99) < 55)) begin
          pv[i]  = 1'b1;
          pwe[i] = 1'($urandom_range(0, 1));
          pad[i] = 8'h80 + 8'($urandom_range(0, 7));
          pwd[i] = $urandom;
        end
        set_a(i, pv[i], pwe[i], pad[i], pwd[i]);
      end
      #1;
      g = -1;
      for (int k = 1; k <= NA; k++) begin
        j = (mptr + k) % NA;
        if (g < 0 && pv[j]) g = j;
      end
      exp_ready = (g >= 0) ? (NA'(1) << g) : '0;
      checks++;
      if (a_ready !== exp_ready) begin errors++; $display("FAIL rand_ready: got %b exp %b", a_ready, exp_ready); end
      checks++;
      if (a_ram_en !== (g >= 0)) begin errors++; $display("FAIL rand_ram_en: got %b exp %b", a_ram_en, (g >= 0)); end
      if (g >= 0) begin
        checks++;
        if ({a_ram_we, a_ram_addr, a_ram_wdata} !== {pwe[g], pad[g], pwd[g]}) begin
          errors++;
          $display("FAIL rand_ram_port: got %b/%h/%h exp %b/%h/%h", a_ram_we, a_ram_addr, a_ram_wdata, pwe[g], pad[g], pwd[g]);
        end
      end
      checks++;
      if (a_rsp_valid !== exp_rsp) begin errors++; $display("FAIL rand_rsp_valid: got %b exp %b", a_rsp_valid, exp_rsp); end
      if (exp_rsp != '0) begin
        checks++;
        if (a_rsp_data !== exp_data) begin errors++; $display("FAIL rand_rsp_data: got %h exp %h", a_rsp_data, exp_data); end
      end
      nxt_rsp  = '0;
      nxt_data = '0;
      if (g >= 0) begin
        mptr  = g;
        pv[g] = 1'b0;
        if (pwe[g]) begin
          mdl[pad[g]] = pwd[g];
        end else begin
          nxt_rsp  = NA'(1) << g;
          nxt_data = mdl[pad[g]];
        end
      end
      exp_rsp  = nxt_rsp;
      exp_data = nxt_data;
    end
    @(negedge clk);
    a_valid = '0;
  endtask

`ifdef RAM_ARBITER_STATS_EN
  task automatic test_stats;
    do_reset;
    @(negedge clk);
    a_valid = '0;
    set_a(1, 1'b1, 1'b0, 8'h50, 32'h0);
    #1;
    checks++; if (a_cnt !== '0) begin errors++; $display("FAIL cnt_clear: got %h exp 0", a_cnt); end
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (a_cnt[16 +: 16] !== 16'hFFFE) begin errors++; $display("FAIL cnt_fffe: got %h exp fffe", a_cnt[16 +: 16]); end
    repeat (70000 - 65534) @(posedge clk);
    #1;
    checks++; if (a_cnt[16 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h exp ffff", a_cnt[16 +: 16]); end
    checks++; if (a_cnt[0 +: 16] !== 16'h0) begin errors++; $display("FAIL cnt_other: got %h exp 0", a_cnt[0 +: 16]); end
    @(negedge clk);
    a_valid = '0;
  endtask
`endif

  initial begin
    rst     = 1'b1;
    a_valid = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    test_reset;
    test_write_read;
    test_round_robin;
    test_alternate;
    test_reset_mid;
    test_rdelay0;
    test_random;
`ifdef RAM_ARBITER_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the RAM address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the RAM data width.
REQ-004 The block SHALL have parameter RDELAY, default 1, meaning the attached RAM read latency (0 or 1).
REQ-005 The block SHALL have port clk, input, 1, the only clock; all logic on the rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ, per-requester access request.
REQ-008 The block SHALL have port req_we, input, NUM_REQ, per-requester write (1) or read (0).
REQ-009 The block SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH, packed addresses, requester i at slice i.
REQ-010 The block SHALL have port req_wdata, input, NUM_REQ*DATA_WIDTH, packed write data.
REQ-011 The block SHALL have port req_ready, output, NUM_REQ, one-hot grant; request accepted when valid and ready.
REQ-012 The block SHALL have port rsp_valid, output, NUM_REQ, one-hot read-response strobe.
REQ-013 The block SHALL have port rsp_data, output, DATA_WIDTH, read data shared by all requesters.
REQ-014 The block SHALL have ports ram_en, ram_we (output, 1), ram_addr (output, ADDR_WIDTH), ram_wdata (output, DATA_WIDTH), driving the single RAM port.
REQ-015 The block SHALL have ports ram_data (input, DATA_WIDTH) and ram_valid (input, 1), the RAM read return.

Function
REQ-016 The block SHALL grant at most one requester per cycle, combinationally from req_valid and the round-robin pointer.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; pointer updates only on a grant.
REQ-018 With no valid request, req_ready SHALL be all-zero and ram_en 0.
REQ-019 On a grant to i, ram_en=1, ram_we=req_we[i], ram_addr/ram_wdata = slice i, same cycle.
REQ-020 For a granted read, rsp_valid[i] SHALL assert exactly RDELAY cycles after the grant cycle, with rsp_data=ram_data.
REQ-021 For RDELAY=1 the grantee id and read flag SHALL be registered one stage; for RDELAY=0 rsp_valid is combinational from the grant.
REQ-022 rsp_valid SHALL be qualified by ram_valid; writes SHALL never produce rsp_valid.
REQ-023 Throughput SHALL be one access per cycle; back-to-back grants to one requester SHALL be allowed when it is the only one valid.
REQ-024 A requester SHALL hold valid/we/addr/wdata stable until accepted; the block SHALL NOT buffer requests.
REQ-025 Responses SHALL have no backpressure; requesters always accept rsp_valid.
REQ-026 Write at cycle t then read of same address at t+1 SHALL return the new data.

Reset
REQ-027 During rst: req_ready=0, ram_en=0, rsp_valid=0, rsp_data=0, pointer=NUM_REQ-1 (requester 0 wins first).
REQ-028 Reset asserted mid-operation SHALL drop any in-flight read response; no rsp_valid the cycle after rst deasserts.

Configuration
REQ-029 Macro RAM_ARBITER_STATS_EN SHALL, when defined, add output grant_cnt (NUM_REQ*16), per-requester saturating grant counters, cleared by rst.
REQ-030 Without RAM_ARBITER_STATS_EN the grant_cnt port and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package ram_arbiter_pkg SHALL hold MAX_REQ=8, the grant-id typedef (3 bits), and the counter width constant (16).
REQ-032 Sub-module rr_arbiter (NUM_REQ request in, one-hot grant out, pointer register) SHALL implement the arbitration.

Verification
REQ-033 Only req 0 writes addr 0x10 data 0xA5A5A5A5, then reads it -> rsp_valid[0] one cycle after read grant, rsp_data 0xA5A5A5A5.
REQ-034 Reqs 0,1 both valid with reads for 4 cycles after reset -> grants 0,1,0,1; responses in same order, RDELAY later.
REQ-035 NUM_REQ=4, only 1 and 3 valid -> grants alternate 1,3,1,3; 0 and 2 never ready.
REQ-036 Read granted, rst pulsed next cycle -> no rsp_valid; first post-reset grant goes to requester 0.
REQ-037 RDELAY=0, single read of pre-written addr 0x02=0x1234 -> rsp_valid and rsp_data same cycle as grant.
REQ-038 With RAM_ARBITER_STATS_EN, 70000 grants to req 1 -> grant_cnt[1] saturates at 0xFFFF.
